// File: rtl/addsub_pipe_if.sv
// Valid/ready bus for the pipelined add/subtract unit: operand beat in, result beat out.
interface addsub_pipe_if #(
    parameter int WIDTH = 36
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic [1:0]       in_sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_sat, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_sat, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_ovf
    );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined add/subtract: carry chain cut into STAGES registered chunks, optional
// unsigned/signed saturation and raw carry/overflow flags in the last stage.
module addsub_pipe #(
    parameter int WIDTH  = 36,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    addsub_pipe_if.slave io
);
    localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;
    localparam int MSB   = WIDTH - 1;

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH) begin : g_bad_param
        $error("addsub_pipe: need WIDTH >= 2 and 1 <= STAGES <= WIDTH");
    end

    // One in-flight beat: operands ride along so later chunks and the flag logic can use them.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] beff;
        logic [WIDTH-1:0] sum;
        logic             cy;
        logic             ovf;
        logic             sub;
        logic [1:0]       sat;
    } stage_t;

    stage_t st_q  [STAGES];
    stage_t st_d  [STAGES];
    logic   vld_q [STAGES];
    stage_t in_beat;
    logic   stall;

    assign stall       = vld_q[STAGES-1] & ~io.out_ready;
    assign io.in_ready = ~stall;

    always_comb begin
        in_beat      = '0;
        in_beat.a    = io.in_a;
        in_beat.beff = io.in_b ^ {WIDTH{io.in_sub}};
        in_beat.cy   = io.in_sub;
        in_beat.sub  = io.in_sub;
        in_beat.sat  = io.in_sat;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;
        // A high STAGES count can leave trailing stages with nothing to add.
        localparam int CW = (LO >= WIDTH) ? 0 : ((WIDTH - LO < CHUNK) ? WIDTH - LO : CHUNK);

        stage_t cur;
        stage_t added;
        stage_t nxt;

        if (k == 0) begin : g_first
            assign cur = in_beat;
        end else begin : g_next
            assign cur = st_q[k-1];
        end

        if (CW > 0) begin : g_add
            logic [CW:0] csum;
            assign csum = {1'b0, cur.a[LO +: CW]} + {1'b0, cur.beff[LO +: CW]} + {{CW{1'b0}}, cur.cy};
            always_comb begin
                added              = cur;
                added.sum[LO +: CW] = csum[CW-1:0];
                added.cy           = csum[CW];
            end
        end else begin : g_pass
            assign added = cur;
        end

        if (k == STAGES - 1) begin : g_last
            logic c_msb;
            // Carry into the MSB recovered from the finished sum bit and its operands.
            assign c_msb = added.sum[MSB] ^ added.a[MSB] ^ added.beff[MSB];
            always_comb begin
                nxt     = added;
                nxt.ovf = c_msb ^ added.cy;
                case (added.sat)
                    2'b01: if (added.sub ? ~added.cy : added.cy)
                               nxt.sum = added.sub ? '0 : '1;
                    2'b10: if (nxt.ovf)
                               nxt.sum = added.a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                      : {1'b0, {(WIDTH-1){1'b1}}};
                    default: ;
                endcase
            end
        end else begin : g_mid
            assign nxt = added;
        end

        assign st_d[k] = nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                st_q[i]  <= '0;
                vld_q[i] <= 1'b0;
            end
        end else if (!stall) begin
            vld_q[0] <= io.in_valid;
            for (int i = 1; i < STAGES; i++) vld_q[i] <= vld_q[i-1];
            for (int i = 0; i < STAGES; i++) st_q[i] <= st_d[i];
        end
    end

    assign io.out_valid = vld_q[STAGES-1];
    assign io.out_sum   = st_q[STAGES-1].sum;
    assign io.out_carry = st_q[STAGES-1].cy;
    assign io.out_ovf   = st_q[STAGES-1].ovf;
endmodule

// File: tb/tb_addsub_pipe.sv
// Drives five addsub_pipe instances (STAGES 1,2,3,5,36) in lockstep and checks each
// against an arithmetic reference model, plus directed latency/saturation/reset steps.
module tb_addsub_pipe;
    localparam int W = 36;
    localparam int N = 5;

    function automatic int stg(input int g);
        case (g)
            0: return 1;
            1: return 2;
            2: return 3;
            3: return 5;
            default: return 36;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         drv_valid = 1'b0;
    logic         drv_sub   = 1'b0;
    logic [1:0]   drv_sat   = 2'b00;
    logic [W-1:0] drv_a     = '0;
    logic [W-1:0] drv_b     = '0;
    logic         out_rdy   = 1'b1;

    logic [N-1:0] rdy, ovld, ocy, oovf;
    logic [W-1:0] osum [N];
    logic         all_rdy, vin;

    // Beats are offered only when every instance can take them, so all see the same stream.
    assign all_rdy = &rdy;
    assign vin     = drv_valid & all_rdy;

    for (genvar g = 0; g < N; g++) begin : g_dut
        addsub_pipe_if #(.WIDTH(W)) bus ();
        assign bus.in_valid  = vin;
        assign bus.in_a      = drv_a;
        assign bus.in_b      = drv_b;
        assign bus.in_sub    = drv_sub;
        assign bus.in_sat    = drv_sat;
        assign bus.out_ready = out_rdy;
        assign rdy[g]        = bus.in_ready;
        assign ovld[g]       = bus.out_valid;
        assign osum[g]       = bus.out_sum;
        assign ocy[g]        = bus.out_carry;
        assign oovf[g]       = bus.out_ovf;
        addsub_pipe #(.WIDTH(W), .STAGES(stg(g))) dut (.clk(clk), .rst_n(rst_n), .io(bus));
    end

    int           checks = 0;
    int           failures = 0;
    logic [37:0]  exp_list [$];
    int           rd_idx [N];
    logic [37:0]  last_out [N];
    logic [37:0]  prev_out [N];
    logic [N-1:0] prev_hold = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic logic [37:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sub, input logic [1:0] sat);
        longint ua, ub, sa, sb, ur, sr;
        logic c, o;
        logic [W-1:0] s;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ur = sub ? ua - ub : ua + ub;
        sr = sub ? sa - sb : sa + sb;
        c  = sub ? (ua >= ub) : (ur >= (longint'(1) << W));
        o  = (sr > ((longint'(1) << (W-1)) - 1)) || (sr < -(longint'(1) << (W-1)));
        s  = ur[W-1:0];
        if (sat == 2'b01 && !sub && c) s = '1;
        if (sat == 2'b01 && sub && !c) s = '0;
        if (sat == 2'b10 && o) s = (sr > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
        return {s, c, o};
    endfunction

    task automatic monitor();
        logic [37:0] got;
        if (!rst_n) begin
            for (int k = 0; k < N; k++) rd_idx[k] = exp_list.size();
            prev_hold = '0;
            return;
        end
        for (int k = 0; k < N; k++) begin
            got = {osum[k], ocy[k], oovf[k]};
            chk($sformatf("in_ready_d%0d", k), rdy[k], !(ovld[k] && !out_rdy));
            if (prev_hold[k]) chk($sformatf("hold_d%0d", k), {ovld[k], got}, {1'b1, prev_out[k]});
            if (ovld[k] && out_rdy) begin
                if (rd_idx[k] < exp_list.size()) begin
                    chk($sformatf("result_d%0d_beat%0d", k, rd_idx[k]), got, exp_list[rd_idx[k]]);
                    rd_idx[k]++;
                    last_out[k] = got;
                end else begin
                    chk($sformatf("extra_beat_d%0d", k), ovld[k], 1'b0);
                end
            end
            prev_hold[k] = ovld[k] && !out_rdy;
            prev_out[k]  = got;
        end
        if (vin) exp_list.push_back(model(drv_a, drv_b, drv_sub, drv_sat));
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_op();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return {1'b0, {(W-1){1'b1}}};
            3: return {1'b1, {(W-1){1'b0}}};
            4: return W'($urandom_range(0, 15));
            default: return r[W-1:0];
        endcase
    endfunction

    task automatic new_rand();
        drv_a   = rand_op();
        drv_b   = rand_op();
        drv_sub = 1'($urandom_range(0, 1));
        drv_sat = 2'($urandom_range(0, 3));
    endtask

    function automatic bit pending();
        for (int k = 0; k < N; k++) if (rd_idx[k] < exp_list.size()) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain();
        int t = 0;
        out_rdy = 1'b1;
        while (pending() && t < 300) begin tick(); t++; end
        for (int k = 0; k < N; k++) chk($sformatf("drained_d%0d", k), rd_idx[k], exp_list.size());
    endtask

    task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sub, input logic [1:0] sat);
        int t = 0;
        drv_a = a; drv_b = b; drv_sub = sub; drv_sat = sat;
        drv_valid = 1'b1;
        while (!vin && t < 100) begin tick(); t++; end
        chk("accept_timeout", vin, 1'b1);
        tick();
        drv_valid = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sub, input logic [1:0] sat,
                            input logic [W-1:0] es, input logic ec, input logic eo);
        send_one(a, b, sub, sat);
        drain();
        for (int k = 0; k < N; k++) chk($sformatf("%s_d%0d", tag, k), last_out[k], {es, ec, eo});
    endtask

    int lat [N];
    int sent, c;
    bit acc;

    initial begin
        for (int k = 0; k < N; k++) begin rd_idx[k] = 0; last_out[k] = '0; end
        // Reset state
        tick(); tick();
        for (int k = 0; k < N; k++)
            chk($sformatf("reset_d%0d", k), {ovld[k], osum[k], ocy[k], oovf[k]}, '0);
        rst_n = 1'b1;
        tick(); tick();

        // 1: 1 + all-ones wraps to 0 with carry; latency STAGES-1 after the accept edge
        for (int k = 0; k < N; k++) lat[k] = -1;
        drv_a = 36'h000000001; drv_b = 36'hFFFFFFFFF; drv_sub = 1'b0; drv_sat = 2'b00;
        drv_valid = 1'b1;
        tick();
        drv_valid = 1'b0;
        for (int j = 0; j < 41; j++) begin
            for (int k = 0; k < N; k++) if (ovld[k] && lat[k] < 0) lat[k] = j;
            tick();
        end
        for (int k = 0; k < N; k++) chk($sformatf("latency_d%0d", k), lat[k], stg(k) - 1);
        drain();
        for (int k = 0; k < N; k++) chk($sformatf("t1_d%0d", k), last_out[k], {36'h0, 1'b1, 1'b0});

        // 2, 3 and extra saturation corners
        directed("t2_wrap", 36'd5, 36'd7, 1'b1, 2'b00, 36'hFFFFFFFFE, 1'b0, 1'b0);
        directed("t2_usat", 36'd5, 36'd7, 1'b1, 2'b01, 36'h000000000, 1'b0, 1'b0);
        directed("t3_smax", 36'h7FFFFFFFF, 36'd1, 1'b0, 2'b10, 36'h7FFFFFFFF, 1'b0, 1'b1);
        directed("t3_smin", 36'h800000000, 36'd1, 1'b1, 2'b10, 36'h800000000, 1'b1, 1'b1);
        directed("uadd_sat", 36'hFFFFFFFFF, 36'd2, 1'b0, 2'b01, 36'hFFFFFFFFF, 1'b1, 1'b0);
        directed("mode11_wrap", 36'h7FFFFFFFF, 36'd1, 1'b0, 2'b11, 36'h800000000, 1'b0, 1'b1);

        // 4: 20 beats with out_ready low for 5 cycles mid-stream
        new_rand(); drv_valid = 1'b1; sent = 0; c = 0;
        while (sent < 20 && c < 200) begin
            out_rdy = !(c >= 8 && c < 13);
            if (c == 10) chk("t4_ready_low_d2", rdy[2], 1'b0);
            acc = vin;
            tick(); c++;
            if (acc) begin sent++; new_rand(); end
        end
        drv_valid = 1'b0;
        chk("t4_sent", sent, 20);
        drain();

        // 5: reset with 3 beats in flight
        out_rdy = 1'b1;
        drv_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin new_rand(); tick(); end
        drv_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < N; k++) chk($sformatf("t5_async_d%0d", k), {ovld[k], osum[k]}, '0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) tick();
        directed("t5_after", 36'd3, 36'd4, 1'b0, 2'b00, 36'd7, 1'b0, 1'b0);

        // 6: 10000 random ops, random valid and out_ready
        new_rand(); drv_valid = 1'b1; sent = 0; c = 0;
        while (sent < 10000 && c < 60000) begin
            out_rdy = ($urandom_range(0, 3) != 0);
            acc = vin;
            tick(); c++;
            if (acc) sent++;
            if (acc || !drv_valid) begin
                new_rand();
                drv_valid = ($urandom_range(0, 3) != 0);
            end
        end
        drv_valid = 1'b0;
        chk("t6_sent", sent, 10000);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
